lbp_host_mem: RTL and testbench

Host-side image/result memory that serves the gray-image read protocol and absorbs the LBP write stream; it is the responder end of the `gray_*` / `lbp_*` interface driven by the LBP engine. The image is streamed in through a load port. `gray_ready` is raised once all W×H pixels are stored. Read requests are answered and LBP results are captured into a result RAM. When the engine raises `finish`, the block checks the write count and exposes results on a readback port. It sits between the system loader/checker and the LBP engine, and doubles as the verification host model.

---
 rtl/lbp_pkg.sv | 27 ++
 rtl/lbp_res_ram.sv | 33 +++
 rtl/lbp_host_mem.sv | 113 +++++++++++
 tb/tb_lbp_host_mem.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/lbp_pkg.sv
// Shared constants, state encoding and border test for the LBP engine and its host memory.
package lbp_pkg;

    localparam int IMG_W   = 128;
    localparam int IMG_H   = 128;
    localparam int ADDR_W  = 14;
    localparam int PIX_CNT = IMG_W * IMG_H;
    localparam int LBP_CNT = (IMG_W - 2) * (IMG_H - 2);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_SERVE,
        ST_DONE
    } host_state_t;

    // True when the raster address lies on the outer ring of the image, where no LBP result exists.
    function automatic logic is_border(input int unsigned addr,
                                       input int unsigned w = IMG_W,
                                       input int unsigned h = IMG_H);
        int unsigned x;
        int unsigned y;
        x = addr % w;
        y = addr / w;
        return (x == 0) || (x == w - 1) || (y == 0) || (y == h - 1);
    endfunction

endpackage

// File: rtl/lbp_res_ram.sv
// Result RAM: one synchronous write port and one registered read port with read-before-write behaviour.
module lbp_res_ram #(
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 16384
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [DEPTH];

    // NOTE: storage arrays carry no reset so they map onto RAM macros; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // NOTE: non-blocking assignment makes a same-edge read see the pre-write contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/lbp_host_mem.sv
// Host-side image/result memory: loads the gray image, serves engine reads, captures LBP writes, reports completion.
module lbp_host_mem #(
    parameter int IMG_W  = lbp_pkg::IMG_W,
    parameter int IMG_H  = lbp_pkg::IMG_H,
    parameter int ADDR_W = lbp_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [7:0]        load_data,
    output logic              gray_ready,
    input  logic              gray_req,
    input  logic [ADDR_W-1:0] gray_addr,
    output logic [7:0]        gray_data,
    input  logic              lbp_valid,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic [7:0]        lbp_data,
    input  logic              finish,
    output logic              done,
    output logic [ADDR_W:0]   wr_cnt,
    output logic              cnt_ok,
    output logic              err_border,
    output logic              err_proto,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    import lbp_pkg::*;

    localparam int PIX_N = IMG_W * IMG_H;
    localparam int LBP_N = (IMG_W - 2) * (IMG_H - 2);

    host_state_t       state_q, state_d;
    logic [ADDR_W-1:0] ld_ptr;
    logic [ADDR_W:0]   wr_cnt_d;
    logic              load_fire;
    logic              lbp_fire;
    logic              proto_evt;
    logic [7:0]        img [PIX_N];

    assign load_fire = load_valid && (state_q == ST_LOAD);
    assign lbp_fire  = lbp_valid && (state_q == ST_SERVE);
    // Results are only accepted while serving; any engine or loader activity in the wrong phase is flagged.
    assign proto_evt = (load_valid && (state_q != ST_LOAD))
                    || (gray_req && (state_q != ST_SERVE))
                    || (lbp_valid && (state_q != ST_SERVE));

    assign gray_ready = (state_q == ST_SERVE);
    assign done       = (state_q == ST_DONE);
    assign gray_data  = img[gray_addr];

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt;
        if (lbp_fire && (wr_cnt != '1)) begin
            wr_cnt_d = wr_cnt + 1'b1;
        end
        case (state_q)
            ST_LOAD:  if (load_fire && (ld_ptr == ADDR_W'(PIX_N - 1))) state_d = ST_SERVE;
            ST_SERVE: if (finish) state_d = ST_DONE;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_LOAD;
            ld_ptr     <= '0;
            wr_cnt     <= '0;
            cnt_ok     <= 1'b0;
            err_border <= 1'b0;
            err_proto  <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_cnt  <= wr_cnt_d;
            if (load_fire) begin
                ld_ptr <= ld_ptr + 1'b1;
            end
            // The count is judged including a write that lands in the same cycle as finish.
            if ((state_q == ST_SERVE) && finish) begin
                cnt_ok <= (wr_cnt_d == (ADDR_W + 1)'(LBP_N));
            end
            if (lbp_fire && is_border(32'(lbp_addr), IMG_W, IMG_H)) begin
                err_border <= 1'b1;
            end
            if (proto_evt) begin
                err_proto <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_fire) begin
            img[ld_ptr] <= load_data;
        end
    end

    lbp_res_ram #(
        .ADDR_W (ADDR_W),
        .DEPTH  (PIX_N)
    ) u_res_ram (
        .clk   (clk),
        .reset (reset),
        .we    (lbp_fire),
        .waddr (lbp_addr),
        .wdata (lbp_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_lbp_host_mem.sv
// Self-checking bench for lbp_host_mem: load, serve table, engine runs, reset and DONE corner cases.
module tb_lbp_host_mem;

    import lbp_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_valid;
    logic [7:0]        load_data;
    logic              gray_ready;
    logic              gray_req;
    logic [ADDR_W-1:0] gray_addr;
    logic [7:0]        gray_data;
    logic              lbp_valid;
    logic [ADDR_W-1:0] lbp_addr;
    logic [7:0]        lbp_data;
    logic              finish;
    logic              done;
    logic [ADDR_W:0]   wr_cnt;
    logic              cnt_ok;
    logic              err_border;
    logic              err_proto;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;

    int n_tests = 0;
    int n_fail  = 0;

    lbp_host_mem dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .gray_ready (gray_ready),
        .gray_req   (gray_req),
        .gray_addr  (gray_addr),
        .gray_data  (gray_data),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .lbp_data   (lbp_data),
        .finish     (finish),
        .done       (done),
        .wr_cnt     (wr_cnt),
        .cnt_ok     (cnt_ok),
        .err_border (err_border),
        .err_proto  (err_proto),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] waddr;
        logic [7:0]        wdata;
        logic [ADDR_W-1:0] raddr;
        logic              chk_rd;
        logic [7:0]        exp_rd;
        logic [ADDR_W:0]   exp_cnt;
        logic              exp_bd;
        logic [ADDR_W-1:0] gaddr;
        logic [7:0]        exp_g;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        gray_req   = 1'b0;
        gray_addr  = '0;
        lbp_valid  = 1'b0;
        lbp_addr   = '0;
        lbp_data   = '0;
        finish     = 1'b0;
        rd_addr    = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic load_image(input int n_beats, input bit chk);
        for (int i = 0; i < n_beats; i++) begin
            load_valid = 1'b1;
            load_data  = i[7:0];
            step();
            if (chk && i == PIX_CNT - 2) check("gray_ready_before_last", 32'(gray_ready), 32'd0);
            if (chk && i == PIX_CNT - 1) check("gray_ready_after_last", 32'(gray_ready), 32'd1);
        end
        load_valid = 1'b0;
    endtask

    function automatic logic [ADDR_W-1:0] interior_addr(input int k);
        int x;
        int y;
        x = 1 + (k % (IMG_W - 2));
        y = 1 + (k / (IMG_W - 2));
        return ADDR_W'(y * IMG_W + x);
    endfunction

    function automatic logic [7:0] res_val(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    // Engine model: writes the first n interior pixels in raster order; optionally raises finish with the last one.
    task automatic engine_writes(input int n, input bit finish_on_last);
        for (int k = 0; k < n; k++) begin
            lbp_valid = 1'b1;
            lbp_addr  = interior_addr(k);
            lbp_data  = res_val(interior_addr(k));
            finish    = finish_on_last && (k == n - 1);
            step();
            if (finish_on_last && k == n - 2) check("done_before_finish", 32'(done), 32'd0);
        end
        lbp_valid = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1'b1, 14'd129, 8'hA5, 14'd130, 1'b0, 8'h00, 15'd1, 1'b0, 14'd129,   8'h81};
        tbl[1] = '{1'b0, 14'd0,   8'h00, 14'd129, 1'b1, 8'hA5, 15'd1, 1'b0, 14'h3FFF,  8'hFF};
        tbl[2] = '{1'b1, 14'd129, 8'h5A, 14'd129, 1'b1, 8'hA5, 15'd2, 1'b0, 14'd256,   8'h00};
        tbl[3] = '{1'b0, 14'd0,   8'h00, 14'd129, 1'b1, 8'h5A, 15'd2, 1'b0, 14'd383,   8'h7F};
        tbl[4] = '{1'b1, 14'd130, 8'h3C, 14'd129, 1'b1, 8'h5A, 15'd3, 1'b0, 14'd5000,  8'h88};
        tbl[5] = '{1'b1, 14'd0,   8'h11, 14'd130, 1'b1, 8'h3C, 15'd4, 1'b1, 14'd1,     8'h01};
        tbl[6] = '{1'b1, 14'd127, 8'h22, 14'd0,   1'b1, 8'h11, 15'd5, 1'b1, 14'd127,   8'h7F};
        tbl[7] = '{1'b0, 14'd0,   8'h00, 14'd127, 1'b1, 8'h22, 15'd5, 1'b1, 14'd16256, 8'h80};

        do_reset();
        check("rst_gray_ready", 32'(gray_ready), 32'd0);
        check("rst_done",       32'(done),       32'd0);
        check("rst_wr_cnt",     32'(wr_cnt),     32'd0);
        check("rst_cnt_ok",     32'(cnt_ok),     32'd0);
        check("rst_err_border", 32'(err_border), 32'd0);
        check("rst_err_proto",  32'(err_proto),  32'd0);
        check("rst_rd_data",    32'(rd_data),    32'd0);

        gray_req = 1'b1;
        step();
        gray_req = 1'b0;
        check("proto_req_in_load", 32'(err_proto), 32'd1);

        // Partial load then reset: a full 16384-beat reload is needed before gray_ready.
        load_image(5000, 1'b0);
        check("partial_no_ready", 32'(gray_ready), 32'd0);
        do_reset();
        check("reset_clears_proto", 32'(err_proto), 32'd0);
        check("reset_no_ready",     32'(gray_ready), 32'd0);
        load_image(PIX_CNT, 1'b1);

        gray_addr = 14'd129;
        #1;
        check("gray_129", 32'(gray_data), 32'h81);

        gray_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            lbp_valid = tbl[i].wr;
            lbp_addr  = tbl[i].waddr;
            lbp_data  = tbl[i].wdata;
            rd_addr   = tbl[i].raddr;
            gray_addr = tbl[i].gaddr;
            #1;
            check($sformatf("vec%0d_gray", i), 32'(gray_data), 32'(tbl[i].exp_g));
            step();
            if (tbl[i].chk_rd) check($sformatf("vec%0d_rd", i), 32'(rd_data), 32'(tbl[i].exp_rd));
            check($sformatf("vec%0d_cnt", i), 32'(wr_cnt), 32'(tbl[i].exp_cnt));
            check($sformatf("vec%0d_border", i), 32'(err_border), 32'(tbl[i].exp_bd));
        end
        gray_req  = 1'b0;
        lbp_valid = 1'b0;
        check("serve_req_no_proto", 32'(err_proto), 32'd0);

        // Bring the count to one short of complete, then finish with no write.
        engine_writes(LBP_CNT - 1 - 5, 1'b0);
        finish = 1'b1;
        step();
        check("short_done",   32'(done),   32'd1);
        check("short_cnt_ok", 32'(cnt_ok), 32'd0);
        check("short_wr_cnt", 32'(wr_cnt), 32'(LBP_CNT - 1));
        check("short_border_sticky", 32'(err_border), 32'd1);
        finish     = 1'b0;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        check("done_terminal",      32'(done),      32'd1);
        check("proto_load_in_done", 32'(err_proto), 32'd1);

        // Complete run: every interior pixel, finish coinciding with the last write.
        do_reset();
        load_image(PIX_CNT, 1'b0);
        engine_writes(LBP_CNT, 1'b1);
        check("full_done",       32'(done),       32'd1);
        check("full_cnt_ok",     32'(cnt_ok),     32'd1);
        check("full_wr_cnt",     32'(wr_cnt),     32'(LBP_CNT));
        check("full_ready_low",  32'(gray_ready), 32'd0);
        check("full_err_border", 32'(err_border), 32'd0);
        check("full_err_proto",  32'(err_proto),  32'd0);
        finish  = 1'b0;
        rd_addr = interior_addr(LBP_CNT - 1);
        step();
        check("readback_last", 32'(rd_data), 32'(res_val(interior_addr(LBP_CNT - 1))));

        lbp_valid = 1'b1;
        lbp_addr  = 14'd129;
        lbp_data  = 8'hEE;
        rd_addr   = 14'd129;
        step();
        lbp_valid = 1'b0;
        check("done_write_cnt", 32'(wr_cnt),    32'(LBP_CNT));
        check("done_write_proto", 32'(err_proto), 32'd1);
        step();
        check("done_write_ignored", 32'(rd_data), 32'(res_val(14'd129)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
